profile_settings: RTL and testbench
===================================

# profile_settings

Datapath responder for the user-settings menu FSM. It consumes the per-digit increment pulses, the digit-advance `update` pulse and the 5-bit `displayMode` code, and holds BCD edit digits for the field being edited. On the last digit of each field it range-checks the value and commits it to binary registers (wheel size, weight, height, age, gender). The committed values feed the speed, distance and calorie datapaths; the edit digits feed the display driver.

## Interface
- `WHEEL_DEF`, 214: reset wheel circumference, cm
- `WEIGHT_DEF`, 70: reset weight, kg
- `HEIGHT_DEF`, 175: reset height, cm
- `AGE_DEF`, 30: reset age, years
- `Clock`  in  1  system clock, rising edge
- `nReset`  in  1  reset, asynchronous, active-low
- `displayMode`  in  5  menu code: 0–5 normal display; 6/7/8 wheel d2/d1/d0; 9/10/11 weight d2/d1/d0; 12/13/14 height d2/d1/d0; 15/16 age d1/d0; 17 gender
- `incr`  in  3  one-cycle increment pulse; bit 2 = hundreds (gender toggle at code 17), bit 1 = tens, bit 0 = units
- `update`  in  1  one-cycle digit-advance pulse
- `wheel_cm`  out  10  committed wheel size
- `weight_kg`  out  10  committed weight
- `height_cm`  out  10  committed height
- `age_yr`  out  7  committed age
- `gender`  out  1  committed gender, 0 = male, 1 = female
- `edit_d2`, `edit_d1`, `edit_d0`  out  4 each  BCD edit digits of the current field
- `settings_changed`  out  1  one-cycle pulse on an accepted commit
- `commit_err`  out  1  one-cycle pulse on a rejected commit
- `profile_done`  out  1  one-cycle pulse on gender commit

## Operation
- Field decode from `displayMode`: WHEEL 6–8, WEIGHT 9–11, HEIGHT 12–14, AGE 15–16, GENDER 17, NONE otherwise.
- Registered `prev_mode`. Entry = `displayMode` is 6, 9, 12, 15 or 17 and `prev_mode` differs. On entry the edit digits are reloaded from the committed value of that field as BCD. AGE: d2 = 0. GENDER: d2 = d1 = 0, d0 = `gender`.
- Increment is accepted only when the `incr` bit matches the digit selected by `displayMode`:
  - bit 2 at codes 6, 9, 12; bit 1 at 7, 10, 13, 15; bit 0 at 8, 11, 14, 16; bit 2 at 17.
  - Non-matching bits are ignored.
- Digit increment: 0→1→…→9→0 wrap, with no carry into the neighbouring digit. At code 17, `incr[2]` toggles d0 between 0 and 1.
- Commit occurs when `update` is high at codes 8, 11, 14, 16 or 17.
  - value = d2·100 + d1·10 + d0 (10-bit).
  - Ranges, inclusive: wheel 100–299, weight 20–250, height 100–250, age 10–99. Gender is always valid.
  - In range: write the committed register and pulse `settings_changed`. At code 17, also pulse `profile_done`.
  - Out of range: committed register unchanged, pulse `commit_err`, edit digits reload from the committed value.
- `update` at any other edit code: no register effect.
- Priority when events coincide in one cycle: entry reload > `update` commit > `incr`. The losing event is dropped.
- At codes 0–5 and 18–31, `incr` and `update` are ignored and the edit digits hold.

## Timing
- Reset (async) values:
  - committed registers = parameter defaults, `gender` = 0;
  - edit digits = 0;
  - `prev_mode` = 0;
  - all pulse outputs = 0.
- Reset mid-edit discards the edit digits. Committed values return to the defaults.
- Increment: edit digit changes at the edge that samples `incr`, visible the next cycle. Back-to-back `incr` pulses each count.
- Entry reload: digits are valid in the cycle after `displayMode` first shows the entry code.
- Commit: the committed register and the `settings_changed`/`commit_err`/`profile_done` pulses are all registered, valid 1 cycle after the sampled `update`, and high for exactly 1 cycle.
- Committed outputs are stable at all other times. Downstream blocks may sample them on any cycle.

## Test plan
- Reset: after `nReset` release, `wheel_cm` = 214, `weight_kg` = 70, `height_cm` = 175, `age_yr` = 30, `gender` = 0; all pulse outputs 0.
- Wheel edit and wrap:
  - stimulus: mode 6 → digits 2/1/4; mode 7 with 3× `incr[1]` → d1 = 4; mode 8 with 7× `incr[0]` → d0 wraps 4…9,0,1; then `update`;
  - response: `wheel_cm` = 241 one cycle later, `settings_changed` high 1 cycle.
- Reject:
  - stimulus: mode 9 with 3× `incr[2]` → 370; codes 10, 11 then `update` at 11;
  - response: `commit_err` pulses, `weight_kg` stays 70, edit digits return to 0/7/0.
- Mismatched increment: mode 7 with `incr[2]` and `incr[0]` pulses → edit digits unchanged; mode 3 with any `incr` → no change.
- Gender and priority:
  - stimulus: mode 17 with `incr[2]` → d0 = 1; `update` together with `incr[2]` in the same cycle;
  - response: `gender` = 1, toggle dropped, `profile_done` and `settings_changed` each pulse once.
- Async reset mid-edit:
  - stimulus: drop `nReset` at mode 13 after an accepted height commit of 180;
  - response: `height_cm` returns to 175 immediately, edit digits 0.

Source files
------------

// File: rtl/profile_settings.sv
// Settings-menu datapath: BCD edit digits for the field being edited, range-checked
// commit into the binary profile registers that feed speed, distance and calorie logic.
module profile_settings #(
  parameter int WHEEL_DEF  = 214,
  parameter int WEIGHT_DEF = 70,
  parameter int HEIGHT_DEF = 175,
  parameter int AGE_DEF    = 30
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [4:0] displayMode,
  input  logic [2:0] incr,
  input  logic       update,
  output logic [9:0] wheel_cm,
  output logic [9:0] weight_kg,
  output logic [9:0] height_cm,
  output logic [6:0] age_yr,
  output logic       gender,
  output logic [3:0] edit_d2,
  output logic [3:0] edit_d1,
  output logic [3:0] edit_d0,
  output logic       settings_changed,
  output logic       commit_err,
  output logic       profile_done
);

  logic [9:0] wheel_q, wheel_d, weight_q, weight_d, height_q, height_d;
  logic [6:0] age_q, age_d;
  logic       gender_q, gender_d;
  logic [3:0] d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [4:0] prev_mode_q;
  logic       changed_q, changed_d, err_q, err_d, done_q, done_d;

  logic [9:0] field_val;
  logic [9:0] edit_val;
  logic [3:0] rl_d2, rl_d1, rl_d0;
  logic       entry_code, commit_code, entry, commit, in_range, inc_hit;
  logic [1:0] inc_digit;

  always_comb begin
    field_val = 10'd0;
    case (displayMode)
      5'd6, 5'd7, 5'd8:    field_val = wheel_q;
      5'd9, 5'd10, 5'd11:  field_val = weight_q;
      5'd12, 5'd13, 5'd14: field_val = height_q;
      5'd15, 5'd16:        field_val = {3'd0, age_q};
      5'd17:               field_val = {9'd0, gender_q};
      default:             field_val = 10'd0;
    endcase
  end

  // Reload image of the committed value; age has no hundreds digit, gender lives in d0.
  always_comb begin
    rl_d2 = 4'(field_val / 10'd100);
    rl_d1 = 4'((field_val / 10'd10) % 10'd10);
    rl_d0 = 4'(field_val % 10'd10);
    if (displayMode == 5'd15 || displayMode == 5'd16) rl_d2 = 4'd0;
    if (displayMode == 5'd17) begin
      rl_d2 = 4'd0;
      rl_d1 = 4'd0;
      rl_d0 = {3'd0, gender_q};
    end
  end

  assign entry_code  = (displayMode == 5'd6) || (displayMode == 5'd9) || (displayMode == 5'd12)
                    || (displayMode == 5'd15) || (displayMode == 5'd17);
  assign commit_code = (displayMode == 5'd8) || (displayMode == 5'd11) || (displayMode == 5'd14)
                    || (displayMode == 5'd16) || (displayMode == 5'd17);
  assign entry  = entry_code && (prev_mode_q != displayMode);
  assign commit = update && commit_code;

  assign edit_val = 10'(d2_q) * 10'd100 + 10'(d1_q) * 10'd10 + 10'(d0_q);

  always_comb begin
    in_range = 1'b0;
    case (displayMode)
      5'd8:    in_range = (edit_val >= 10'd100) && (edit_val <= 10'd299);
      5'd11:   in_range = (edit_val >= 10'd20)  && (edit_val <= 10'd250);
      5'd14:   in_range = (edit_val >= 10'd100) && (edit_val <= 10'd250);
      5'd16:   in_range = (edit_val >= 10'd10)  && (edit_val <= 10'd99);
      5'd17:   in_range = 1'b1;
      default: in_range = 1'b0;
    endcase
  end

  always_comb begin
    inc_hit   = 1'b0;
    inc_digit = 2'd0;
    case (displayMode)
      5'd6, 5'd9, 5'd12: begin
        inc_hit   = incr[2];
        inc_digit = 2'd2;
      end
      5'd7, 5'd10, 5'd13, 5'd15: begin
        inc_hit   = incr[1];
        inc_digit = 2'd1;
      end
      5'd8, 5'd11, 5'd14, 5'd16: begin
        inc_hit   = incr[0];
        inc_digit = 2'd0;
      end
      5'd17: begin
        inc_hit   = incr[2];
        inc_digit = 2'd3;
      end
      default: begin
        inc_hit   = 1'b0;
        inc_digit = 2'd0;
      end
    endcase
  end

  // Priority: entry reload, then commit, then increment; losers are dropped.
  always_comb begin
    wheel_d   = wheel_q;
    weight_d  = weight_q;
    height_d  = height_q;
    age_d     = age_q;
    gender_d  = gender_q;
    d2_d      = d2_q;
    d1_d      = d1_q;
    d0_d      = d0_q;
    changed_d = 1'b0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    if (entry) begin
      d2_d = rl_d2;
      d1_d = rl_d1;
      d0_d = rl_d0;
    end else if (commit) begin
      if (in_range) begin
        changed_d = 1'b1;
        case (displayMode)
          5'd8:    wheel_d  = edit_val;
          5'd11:   weight_d = edit_val;
          5'd14:   height_d = edit_val;
          5'd16:   age_d    = edit_val[6:0];
          default: begin
            gender_d = d0_q[0];
            done_d   = 1'b1;
          end
        endcase
      end else begin
        err_d = 1'b1;
        d2_d  = rl_d2;
        d1_d  = rl_d1;
        d0_d  = rl_d0;
      end
    end else if (inc_hit) begin
      case (inc_digit)
        2'd2:    d2_d = (d2_q >= 4'd9) ? 4'd0 : d2_q + 4'd1;
        2'd1:    d1_d = (d1_q >= 4'd9) ? 4'd0 : d1_q + 4'd1;
        2'd0:    d0_d = (d0_q >= 4'd9) ? 4'd0 : d0_q + 4'd1;
        default: d0_d = {3'd0, ~d0_q[0]};
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wheel_q     <= 10'(WHEEL_DEF);
      weight_q    <= 10'(WEIGHT_DEF);
      height_q    <= 10'(HEIGHT_DEF);
      age_q       <= 7'(AGE_DEF);
      gender_q    <= 1'b0;
      d2_q        <= 4'd0;
      d1_q        <= 4'd0;
      d0_q        <= 4'd0;
      prev_mode_q <= 5'd0;
      changed_q   <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wheel_q     <= wheel_d;
      weight_q    <= weight_d;
      height_q    <= height_d;
      age_q       <= age_d;
      gender_q    <= gender_d;
      d2_q        <= d2_d;
      d1_q        <= d1_d;
      d0_q        <= d0_d;
      prev_mode_q <= displayMode;
      changed_q   <= changed_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign wheel_cm         = wheel_q;
  assign weight_kg        = weight_q;
  assign height_cm        = height_q;
  assign age_yr           = age_q;
  assign gender           = gender_q;
  assign edit_d2          = d2_q;
  assign edit_d1          = d1_q;
  assign edit_d0          = d0_q;
  assign settings_changed = changed_q;
  assign commit_err       = err_q;
  assign profile_done     = done_q;

endmodule

// File: tb/tb_profile_settings.sv
// Scoreboard bench for profile_settings: expectations are queued as stimulus is
// applied and compared against the outputs after the clock edge that produces them.
module tb_profile_settings;

  logic       Clock = 1'b0;
  logic       nReset;
  logic [4:0] displayMode;
  logic [2:0] incr;
  logic       update;
  logic [9:0] wheel_cm, weight_kg, height_cm;
  logic [6:0] age_yr;
  logic       gender;
  logic [3:0] edit_d2, edit_d1, edit_d0;
  logic       settings_changed, commit_err, profile_done;

  profile_settings dut (
    .Clock(Clock), .nReset(nReset), .displayMode(displayMode), .incr(incr), .update(update),
    .wheel_cm(wheel_cm), .weight_kg(weight_kg), .height_cm(height_cm), .age_yr(age_yr),
    .gender(gender), .edit_d2(edit_d2), .edit_d1(edit_d1), .edit_d0(edit_d0),
    .settings_changed(settings_changed), .commit_err(commit_err), .profile_done(profile_done)
  );

  always #5 Clock = ~Clock;

  localparam int S_WHEEL = 0, S_WEIGHT = 1, S_HEIGHT = 2, S_AGE = 3, S_GENDER = 4,
                 S_DIGITS = 5, S_CHG = 6, S_ERR = 7, S_DONE = 8;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      S_WHEEL:  return int'(wheel_cm);
      S_WEIGHT: return int'(weight_kg);
      S_HEIGHT: return int'(height_cm);
      S_AGE:    return int'(age_yr);
      S_GENDER: return int'(gender);
      S_DIGITS: return int'(edit_d2) * 100 + int'(edit_d1) * 10 + int'(edit_d0);
      S_CHG:    return int'(settings_changed);
      S_ERR:    return int'(commit_err);
      default:  return int'(profile_done);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  // One clock cycle with the given inputs; pulses last exactly this cycle.
  task automatic step(input int mode, input int inc, input bit upd);
    @(negedge Clock);
    displayMode = 5'(mode);
    incr        = 3'(inc);
    update      = upd;
    @(posedge Clock);
    #1;
    drain();
  endtask

  task automatic repeat_step(input int mode, input int inc, input int n);
    for (int i = 0; i < n; i++) step(mode, inc, 1'b0);
  endtask

  initial begin
    nReset = 1'b0;
    displayMode = 5'd0;
    incr = 3'd0;
    update = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;

    push("rst_wheel", S_WHEEL, 214);
    push("rst_weight", S_WEIGHT, 70);
    push("rst_height", S_HEIGHT, 175);
    push("rst_age", S_AGE, 30);
    push("rst_gender", S_GENDER, 0);
    push("rst_digits", S_DIGITS, 0);
    push("rst_chg", S_CHG, 0);
    push("rst_err", S_ERR, 0);
    push("rst_done", S_DONE, 0);
    step(0, 0, 1'b0);

    // Wheel: reload, tens x3, units x7 with wrap, commit 241
    push("wheel_entry", S_DIGITS, 214);
    step(6, 0, 1'b0);
    step(7, 0, 1'b0);
    repeat_step(7, 2, 3);
    push("wheel_d1", S_DIGITS, 244);
    step(7, 0, 1'b0);
    repeat_step(8, 1, 6);
    push("wheel_d0_wrap", S_DIGITS, 241);
    step(8, 1, 1'b0);
    push("wheel_commit", S_WHEEL, 241);
    push("wheel_chg", S_CHG, 1);
    push("wheel_noerr", S_ERR, 0);
    step(8, 0, 1'b1);
    push("wheel_chg_end", S_CHG, 0);
    push("wheel_hold", S_WHEEL, 241);
    step(8, 0, 1'b0);

    // Mismatched increments and idle modes leave the digits alone
    step(7, 4, 1'b0);
    push("mismatch_7", S_DIGITS, 241);
    step(7, 1, 1'b0);
    step(3, 7, 1'b0);
    push("idle_mode", S_DIGITS, 241);
    push("idle_upd", S_CHG, 0);
    step(3, 0, 1'b1);

    // Weight: 370 is rejected, digits reload from 70
    push("weight_entry", S_DIGITS, 70);
    step(9, 0, 1'b0);
    repeat_step(9, 4, 2);
    push("weight_d2", S_DIGITS, 370);
    step(9, 4, 1'b0);
    step(10, 0, 1'b0);
    step(11, 0, 1'b0);
    push("weight_err", S_ERR, 1);
    push("weight_nochg", S_CHG, 0);
    push("weight_keep", S_WEIGHT, 70);
    push("weight_reload", S_DIGITS, 70);
    step(11, 0, 1'b1);
    push("weight_err_end", S_ERR, 0);
    step(11, 0, 1'b0);

    // Age: 00 rejected (lower bound), then 99 accepted (upper bound)
    push("age_entry", S_DIGITS, 30);
    step(15, 0, 1'b0);
    repeat_step(15, 2, 7);
    step(16, 0, 1'b0);
    push("age_low_err", S_ERR, 1);
    push("age_keep", S_AGE, 30);
    push("age_reload", S_DIGITS, 30);
    step(16, 0, 1'b1);
    step(15, 0, 1'b0);
    repeat_step(15, 2, 6);
    repeat_step(16, 1, 9);
    push("age_pre", S_DIGITS, 99);
    step(16, 0, 1'b0);
    push("age_commit", S_AGE, 99);
    push("age_chg", S_CHG, 1);
    step(16, 0, 1'b1);

    // Gender: toggle, then update+incr in one cycle -> commit wins
    push("gender_entry", S_DIGITS, 0);
    step(17, 4, 1'b1);
    push("gender_toggle", S_DIGITS, 1);
    step(17, 4, 1'b0);
    push("gender_commit", S_GENDER, 1);
    push("gender_done", S_DONE, 1);
    push("gender_chg", S_CHG, 1);
    push("gender_drop_tgl", S_DIGITS, 1);
    step(17, 4, 1'b1);
    push("gender_done_end", S_DONE, 0);
    push("gender_chg_end", S_CHG, 0);
    step(17, 0, 1'b0);

    // Height: 175 -> 180 commit, then async reset mid-edit
    push("height_entry", S_DIGITS, 175);
    step(12, 0, 1'b0);
    step(13, 2, 1'b0);
    repeat_step(14, 1, 5);
    push("height_pre", S_DIGITS, 180);
    step(14, 0, 1'b0);
    push("height_commit", S_HEIGHT, 180);
    step(14, 0, 1'b1);
    step(13, 2, 1'b0);
    #2;
    nReset = 1'b0;
    #1;
    push("arst_height", S_HEIGHT, 175);
    push("arst_wheel", S_WHEEL, 214);
    push("arst_age", S_AGE, 30);
    push("arst_gender", S_GENDER, 0);
    push("arst_digits", S_DIGITS, 0);
    drain();
    @(negedge Clock);
    nReset = 1'b1;
    step(0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
